lighting_actuator: RTL



---
 rtl/lighting_actuator.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/lighting_actuator.sv
// lighting_actuator: steps the window-shade motor one unit at a time toward the
// requested level and switches lamps one at a time (with a minimum gap between
// toggles) to limit inrush current. Shade and lamp paths run independently.
module lighting_actuator #(
    parameter int STEP_CYCLES = 8,   // cycles per one-unit shade move, >= 2
    parameter int LAMP_GAP    = 4    // minimum cycles between lamp toggles, >= 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  wshade,
    input  logic [15:0] lightstate,
    output logic [3:0]  shade_pos,
    output logic        motor_up,
    output logic        motor_down,
    output logic [15:0] lamp_out,
    output logic        busy
);

    localparam int TW = $clog2(STEP_CYCLES);
    localparam int GW = (LAMP_GAP > 1) ? $clog2(LAMP_GAP) : 1;
    localparam logic [TW-1:0] STEP_LAST = TW'(STEP_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE = TW'(1);
    localparam logic [TW-1:0] TIMER_ZERO = {TW{1'b0}};
    localparam logic [GW-1:0] GAP_LOAD = GW'(LAMP_GAP - 1);
    localparam logic [GW-1:0] GAP_ONE = GW'(1);
    localparam logic [GW-1:0] GAP_ZERO = {GW{1'b0}};

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_UP   = 2'd1,
        S_DOWN = 2'd2,
        S_STOP = 2'd3
    } state_e;

    // Isolates the lowest set bit of a 16-bit vector (two's-complement trick).
    function automatic logic [15:0] lowest_bit(input logic [15:0] v);
        return v & (~v + 16'd1);
    endfunction

    logic [3:0]    shade_tgt_q;
    logic [15:0]   lamp_tgt_q;
    state_e        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [3:0]    shade_pos_q, shade_pos_d;
    logic          motor_up_q, motor_up_d;
    logic          motor_down_q, motor_down_d;
    logic [15:0]   lamp_out_q, lamp_out_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [15:0]   mismatch_s;

    // Capture the requested targets every cycle; all decisions use these copies.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shade_tgt_q <= 4'd0;
            lamp_tgt_q  <= 16'd0;
        end else begin
            shade_tgt_q <= wshade;
            lamp_tgt_q  <= lightstate;
        end
    end

    // Shade FSM next state, step timer and position update.
    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        shade_pos_d = shade_pos_q;
        case (state_q)
            S_IDLE: begin
                timer_d = TIMER_ZERO;
                if (shade_tgt_q > shade_pos_q) begin
                    state_d = S_UP;
                end else if (shade_tgt_q < shade_pos_q) begin
                    state_d = S_DOWN;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_UP: begin
                if (shade_tgt_q <= shade_pos_q) begin
                    // target reached or reversed: drop the partial step
                    state_d = S_STOP;
                    timer_d = TIMER_ZERO;
                end else if (timer_q == STEP_LAST) begin
                    shade_pos_d = shade_pos_q + 4'd1;
                    timer_d     = TIMER_ZERO;
                    if ((shade_pos_q + 4'd1) == shade_tgt_q) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_UP;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            S_DOWN: begin
                if (shade_tgt_q >= shade_pos_q) begin
                    state_d = S_STOP;
                    timer_d = TIMER_ZERO;
                end else if (timer_q == STEP_LAST) begin
                    shade_pos_d = shade_pos_q - 4'd1;
                    timer_d     = TIMER_ZERO;
                    if ((shade_pos_q - 4'd1) == shade_tgt_q) begin
                        state_d = S_STOP;
                    end else begin
                        state_d = S_DOWN;
                    end
                end else begin
                    timer_d = timer_q + TIMER_ONE;
                end
            end
            default: begin
                // S_STOP: one cycle with both motors off
                state_d = S_IDLE;
                timer_d = TIMER_ZERO;
            end
        endcase
        // motor flops follow the state being entered, so they track state_q exactly
        motor_up_d   = (state_d == S_UP);
        motor_down_d = (state_d == S_DOWN);
    end

    // Lamp sequencer: toggle the lowest mismatching lamp, then hold off for the gap.
    always_comb begin
        mismatch_s = lamp_out_q ^ lamp_tgt_q;
        lamp_out_d = lamp_out_q;
        gap_d      = gap_q;
        if (mismatch_s == 16'd0) begin
            gap_d = GAP_ZERO;
        end else if (gap_q == GAP_ZERO) begin
            lamp_out_d = lamp_out_q ^ lowest_bit(mismatch_s);
            gap_d      = GAP_LOAD;
        end else begin
            gap_d = gap_q - GAP_ONE;
        end
    end

    // State, timers and registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            timer_q      <= TIMER_ZERO;
            shade_pos_q  <= 4'd0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            lamp_out_q   <= 16'd0;
            gap_q        <= GAP_ZERO;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            shade_pos_q  <= shade_pos_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            lamp_out_q   <= lamp_out_d;
            gap_q        <= gap_d;
        end
    end

    assign shade_pos  = shade_pos_q;
    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign lamp_out   = lamp_out_q;
    assign busy       = (state_q != S_IDLE) | (shade_tgt_q != shade_pos_q) |
                        (mismatch_s != 16'd0);

endmodule
